// File: rtl/gcd_client_pkg.sv
// Shared definitions for the GCD client: FSM encoding and default parameter values.
package gcd_client_pkg;

    localparam int W_DEFAULT       = 16;
    localparam int MAX_OUT_DEFAULT = 4;
    localparam int TIMEOUT_DEFAULT = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/gcd_client_opgen.sv
// Operand generator: latches seeds at batch start and steps A by a_step on every accepted request.
module gcd_client_opgen #(
    parameter int W = gcd_client_pkg::W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         advance_i,
    input  logic [W-1:0] a0_i,
    input  logic [W-1:0] a_step_i,
    input  logic [W-1:0] b0_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o
);

    logic [W-1:0] a_q, b_q, step_q;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            step_q <= '0;
        end else if (load_i) begin
            a_q    <= a0_i;
            b_q    <= b0_i;
            step_q <= a_step_i;
        end else if (advance_i) begin
            a_q <= a_q + step_q;
        end
    end

    assign a_o = a_q;
    assign b_o = b_q;

endmodule

// File: rtl/gcd_client.sv
// GCD coprocessor client: issues a batch of generated operand pairs, keeps up to MAX_OUT in flight,
// accumulates returned results into a checksum and flags an error if responses stall too long.
module gcd_client
    import gcd_client_pkg::*;
#(
    parameter int W       = W_DEFAULT,
    parameter int MAX_OUT = MAX_OUT_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   count,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] a_step,
    input  logic [W-1:0] b0,
    output logic         operands_val,
    output logic [W-1:0] operands_bits_A,
    output logic [W-1:0] operands_bits_B,
    input  logic         operands_rdy,
    input  logic         result_val,
    input  logic [W-1:0] result_bits,
    output logic         result_rdy,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [W-1:0] checksum,
    output logic [7:0]   result_count
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [OW-1:0] MAX_OUT_V = OW'(MAX_OUT);
    localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);

    state_e        state_q, state_d;
    logic [7:0]    count_q, count_d;
    logic [7:0]    issued_q, issued_d;
    logic [7:0]    received_q, received_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [W-1:0]  checksum_q, checksum_d;
    logic          error_q, error_d;
    logic          operands_val_q, result_rdy_q, busy_q, done_q;

    logic req_fire, rsp_fire, load;

    assign req_fire = operands_val_q & operands_rdy;
    assign rsp_fire = result_val & result_rdy_q;
    assign load     = (state_q == ST_IDLE) & start;

    gcd_client_opgen #(.W(W)) u_opgen (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load),
        .advance_i (req_fire),
        .a0_i      (a0),
        .a_step_i  (a_step),
        .b0_i      (b0),
        .a_o       (operands_bits_A),
        .b_o       (operands_bits_B)
    );

    // NOTE: every next-state variable gets a default first so no latches are inferred.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        issued_d      = issued_q;
        received_d    = received_q;
        outstanding_d = outstanding_q;
        timer_d       = timer_q;
        checksum_d    = checksum_q;
        error_d       = error_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d       = count;
                    issued_d      = '0;
                    received_d    = '0;
                    outstanding_d = '0;
                    timer_d       = '0;
                    checksum_d    = '0;
                    error_d       = 1'b0;
                    state_d       = (count == 8'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (req_fire) issued_d = issued_q + 8'd1;
                if (rsp_fire) begin
                    checksum_d = checksum_q + result_bits;
                    received_d = received_q + 8'd1;
                end
                unique case ({req_fire, rsp_fire})
                    2'b10:   outstanding_d = outstanding_q + OW'(1);
                    2'b01:   outstanding_d = outstanding_q - OW'(1);
                    default: outstanding_d = outstanding_q;
                endcase
                if (rsp_fire)                    timer_d = '0;
                else if (outstanding_q != '0)    timer_d = timer_q + TW'(1);
                if (rsp_fire && received_d == count_q) begin
                    state_d = ST_DONE;
                end else if (timer_d == TIMEOUT_V) begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change cleanly on the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            count_q        <= '0;
            issued_q       <= '0;
            received_q     <= '0;
            outstanding_q  <= '0;
            timer_q        <= '0;
            checksum_q     <= '0;
            error_q        <= 1'b0;
            operands_val_q <= 1'b0;
            result_rdy_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            issued_q       <= issued_d;
            received_q     <= received_d;
            outstanding_q  <= outstanding_d;
            timer_q        <= timer_d;
            checksum_q     <= checksum_d;
            error_q        <= error_d;
            operands_val_q <= (state_d == ST_RUN) && (issued_d < count_d) && (outstanding_d < MAX_OUT_V);
            result_rdy_q   <= (state_d == ST_RUN);
            busy_q         <= (state_d != ST_IDLE);
            done_q         <= (state_d == ST_DONE);
        end
    end

    assign operands_val = operands_val_q;
    assign result_rdy   = result_rdy_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign checksum     = checksum_q;
    assign result_count = received_q;

endmodule

// File: tb/tb_gcd_client.sv
// Directed bench for gcd_client: acts as the GCD coprocessor and scoreboards requests and checksums.
module tb_gcd_client;

    localparam int W       = 16;
    localparam int MAX_OUT = 4;
    localparam int TIMEOUT = 1024;

    logic         clk = 1'b0;
    logic         reset, start, operands_rdy, result_val;
    logic [7:0]   count;
    logic [W-1:0] a0, a_step, b0, result_bits;
    logic         operands_val, result_rdy, busy, done, error;
    logic [W-1:0] operands_bits_A, operands_bits_B, checksum;
    logic [7:0]   result_count;

    int checks = 0;
    int errors = 0;
    int n_req, n_rsp, cycles;
    logic         rsp_en;
    logic [W-1:0] exp_sum;
    logic [31:0]  exp_q[$];
    logic [W-1:0] pend_q[$];

    always #5 clk = ~clk;

    gcd_client #(.W(W), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .count           (count),
        .a0              (a0),
        .a_step          (a_step),
        .b0              (b0),
        .operands_val    (operands_val),
        .operands_bits_A (operands_bits_A),
        .operands_bits_B (operands_bits_B),
        .operands_rdy    (operands_rdy),
        .result_val      (result_val),
        .result_bits     (result_bits),
        .result_rdy      (result_rdy),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .checksum        (checksum),
        .result_count    (result_count)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [W-1:0] gcd(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] a = x;
        logic [W-1:0] b = y;
        logic [W-1:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Expected requests and checksum come from the seeds alone.
    task automatic push_batch(input int cnt, input logic [W-1:0] av, input logic [W-1:0] sv, input logic [W-1:0] bv);
        logic [W-1:0] a_i;
        exp_sum = '0;
        for (int i = 0; i < cnt; i++) begin
            a_i = av + W'(i) * sv;
            exp_q.push_back({a_i, bv});
            exp_sum = exp_sum + gcd(a_i, bv);
        end
    endtask

    // One clock: drive the response channel, predict handshakes at the coming edge, wait for the next negedge.
    task automatic tick();
        logic [31:0] req;
        result_val  = rsp_en && (pend_q.size() > 0);
        result_bits = (pend_q.size() > 0) ? pend_q[0] : '0;
        if (result_val && result_rdy) begin
            void'(pend_q.pop_front());
            n_rsp++;
        end
        if (operands_val && operands_rdy) begin
            n_req++;
            if (exp_q.size() == 0) begin
                check("req_unexpected", 32'd1, 32'd0);
            end else begin
                req = exp_q.pop_front();
                check("req_A", 32'(operands_bits_A), 32'(req[31:16]));
                check("req_B", 32'(operands_bits_B), 32'(req[15:0]));
                pend_q.push_back(gcd(operands_bits_A, operands_bits_B));
            end
        end
        @(negedge clk);
    endtask

    task automatic start_batch(input int cnt, input logic [W-1:0] av, input logic [W-1:0] sv, input logic [W-1:0] bv);
        push_batch(cnt, av, sv, bv);
        n_req  = 0;
        n_rsp  = 0;
        start  = 1'b1;
        count  = 8'(cnt);
        a0     = av;
        a_step = sv;
        b0     = bv;
        tick();
        start  = 1'b0;
        a0     = '1;
        a_step = '1;
        b0     = '1;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic check_pulse_end();
        tick();
        check("done_single_pulse", 32'(done), 32'd0);
        check("idle_not_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; count = '0; a0 = '0; a_step = '0; b0 = '0;
        operands_rdy = 1'b1; result_val = 1'b0; result_bits = '0; rsp_en = 1'b1;
        n_req = 0; n_rsp = 0; exp_sum = '0;
        repeat (3) @(negedge clk);
        check("rst_operands_val", 32'(operands_val), 32'd0);
        check("rst_bits_A", 32'(operands_bits_A), 32'd0);
        check("rst_bits_B", 32'(operands_bits_B), 32'd0);
        check("rst_result_rdy", 32'(result_rdy), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        check("rst_result_count", 32'(result_count), 32'd0);
        reset = 1'b0;
        tick();

        // Single request {12,8} -> result 4.
        start_batch(1, 16'd12, 16'd0, 16'd8);
        wait_done(50, cycles);
        check("b1_checksum", 32'(checksum), 32'd4);
        check("b1_result_count", 32'(result_count), 32'd1);
        check("b1_error", 32'(error), 32'd0);
        check("b1_busy_in_done", 32'(busy), 32'd1);
        check_pulse_end();

        // Stepped operands (10,15),(15,15),(20,15) -> 5+15+5.
        start_batch(3, 16'd10, 16'd5, 16'd15);
        wait_done(50, cycles);
        check("b2_checksum", 32'(checksum), 32'd25);
        check("b2_model_sum", 32'(checksum), 32'(exp_sum));
        check("b2_result_count", 32'(result_count), 32'd3);
        check("b2_reqs", 32'(n_req), 32'd3);
        check_pulse_end();

        // Back-pressure: request must hold steady while operands_rdy is low.
        operands_rdy = 1'b0;
        start_batch(2, 16'd7, 16'd3, 16'd21);
        for (int i = 0; i < 5; i++) begin
            check("bp_val", 32'(operands_val), 32'd1);
            check("bp_A", 32'(operands_bits_A), 32'd7);
            check("bp_B", 32'(operands_bits_B), 32'd21);
            tick();
        end
        check("bp_no_issue", 32'(n_req), 32'd0);
        operands_rdy = 1'b1;
        wait_done(50, cycles);
        check("bp_reqs", 32'(n_req), 32'd2);
        check("bp_checksum", 32'(checksum), 32'(exp_sum));
        check("bp_result_count", 32'(result_count), 32'd2);
        check_pulse_end();

        // No responses: only MAX_OUT requests issue, then the timer fires.
        rsp_en = 1'b0;
        start_batch(8, 16'd1, 16'd1, 16'd1);
        repeat (20) tick();
        check("to_reqs_capped", 32'(n_req), 32'(MAX_OUT));
        check("to_val_low", 32'(operands_val), 32'd0);
        check("to_no_early_error", 32'(error), 32'd0);
        wait_done(TIMEOUT + 100, cycles);
        check("to_done_cycle", 32'(cycles + 20), 32'(TIMEOUT + 1));
        check("to_error", 32'(error), 32'd1);
        check("to_result_count", 32'(result_count), 32'd0);
        check_pulse_end();
        check("to_error_sticky", 32'(error), 32'd1);
        exp_q.delete();
        pend_q.delete();
        rsp_en = 1'b1;

        // Empty batch: done on the next cycle, error cleared by the new start.
        start_batch(0, 16'd5, 16'd5, 16'd5);
        check("zero_done", 32'(done), 32'd1);
        check("zero_checksum", 32'(checksum), 32'd0);
        check("zero_result_count", 32'(result_count), 32'd0);
        check("zero_error_cleared", 32'(error), 32'd0);
        check_pulse_end();

        // Reset in the middle of a batch after two issues.
        rsp_en = 1'b0;
        start_batch(5, 16'd3, 16'd2, 16'd9);
        tick();
        tick();
        check("mid_two_issued", 32'(n_req), 32'd2);
        reset = 1'b1;
        #1;
        check("mid_rst_val", 32'(operands_val), 32'd0);
        check("mid_rst_A", 32'(operands_bits_A), 32'd0);
        check("mid_rst_B", 32'(operands_bits_B), 32'd0);
        check("mid_rst_result_rdy", 32'(result_rdy), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_checksum", 32'(checksum), 32'd0);
        check("mid_rst_result_count", 32'(result_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        pend_q.delete();
        pend_q.push_back(16'd77);
        rsp_en = 1'b1;
        repeat (4) tick();
        check("post_rst_no_consume", 32'(pend_q.size()), 32'd1);
        check("post_rst_rdy_low", 32'(result_rdy), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        pend_q.delete();

        // Clean batch after reset.
        start_batch(4, 16'd100, 16'd7, 16'd60);
        wait_done(80, cycles);
        check("final_checksum", 32'(checksum), 32'(exp_sum));
        check("final_result_count", 32'(result_count), 32'd4);
        check("final_error", 32'(error), 32'd0);
        check_pulse_end();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
